// File: rtl/tea_decrypt_iter.sv
// Iterative TEA decryptor: one decryption round per clock behind valid/ready
// handshakes on both the ciphertext input and the plaintext output.
module tea_decrypt_iter #(
    parameter int unsigned ROUNDS = 32,
    parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] v0_in,
    input  logic [31:0] v1_in,
    input  logic [31:0] k0,
    input  logic [31:0] k1,
    input  logic [31:0] k2,
    input  logic [31:0] k3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] v0_out,
    output logic [31:0] v1_out,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Decryption walks the key schedule backwards from the final encryptor sum.
    localparam logic [31:0] SUM_INIT   = 32'(DELTA * ROUNDS);
    localparam logic [5:0]  LAST_ROUND = 6'(ROUNDS - 1);

    state_t       state_q, state_d;
    logic [5:0]   cnt_q, cnt_d;
    logic [31:0]  v0_q, v0_d;
    logic [31:0]  v1_q, v1_d;
    logic [31:0]  sum_q, sum_d;
    logic [127:0] key_q, key_d;
    logic [31:0]  v0_out_q, v0_out_d;
    logic [31:0]  v1_out_q, v1_out_d;

    logic [31:0] key_w0, key_w1, key_w2, key_w3;
    logic [31:0] v1_round, v0_round;

    assign key_w0 = key_q[31:0];
    assign key_w1 = key_q[63:32];
    assign key_w2 = key_q[95:64];
    assign key_w3 = key_q[127:96];

    // v0 is un-mixed with the freshly recovered v1, mirroring encryption order.
    assign v1_round = v1_q - (((v0_q << 4) + key_w2) ^ (v0_q + sum_q) ^ ((v0_q >> 5) + key_w3));
    assign v0_round = v0_q - (((v1_round << 4) + key_w0) ^ (v1_round + sum_q) ^ ((v1_round >> 5) + key_w1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        v0_d     = v0_q;
        v1_d     = v1_q;
        sum_d    = sum_q;
        key_d    = key_q;
        v0_out_d = v0_out_q;
        v1_out_d = v1_out_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    v0_d    = v0_in;
                    v1_d    = v1_in;
                    key_d   = {k3, k2, k1, k0};
                    sum_d   = SUM_INIT;
                    cnt_d   = 6'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                v0_d  = v0_round;
                v1_d  = v1_round;
                sum_d = sum_q - DELTA;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_ROUND) begin
                    v0_out_d = v0_round;
                    v1_out_d = v1_round;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            v0_q     <= 32'd0;
            v1_q     <= 32'd0;
            sum_q    <= 32'd0;
            key_q    <= 128'd0;
            v0_out_q <= 32'd0;
            v1_out_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            v0_q     <= v0_d;
            v1_q     <= v1_d;
            sum_q    <= sum_d;
            key_q    <= key_d;
            v0_out_q <= v0_out_d;
            v1_out_q <= v1_out_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign v0_out    = v0_out_q;
    assign v1_out    = v1_out_q;

endmodule

// File: tb/tb_tea_decrypt_iter.sv
// Scoreboard bench for tea_decrypt_iter: ciphertexts come from an independent
// TEA encryption model and decrypted results are checked against the plaintexts.
module tb_tea_decrypt_iter;

    localparam int          ROUNDS = 32;
    localparam logic [31:0] DELTA  = 32'h9E3779B9;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] v0_in = 32'd0, v1_in = 32'd0;
    logic [31:0] k0 = 32'd0, k1 = 32'd0, k2 = 32'd0, k3 = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] v0_out, v1_out;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus lists consumed by process_blocks.
    logic [31:0]  st_v0[$];
    logic [31:0]  st_v1[$];
    logic [127:0] st_key[$];
    logic [63:0]  ex_pt[$];

    tea_decrypt_iter #(.ROUNDS(ROUNDS), .DELTA(DELTA)) dut (
        .clk(clk), .nrst(nrst),
        .in_valid(in_valid), .in_ready(in_ready),
        .v0_in(v0_in), .v1_in(v1_in),
        .k0(k0), .k1(k1), .k2(k2), .k3(k3),
        .out_valid(out_valid), .out_ready(out_ready),
        .v0_out(v0_out), .v1_out(v1_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] tea_enc(input logic [31:0] p0, input logic [31:0] p1,
                                            input logic [127:0] key);
        logic [31:0] a, b, s;
        a = p0; b = p1; s = 32'd0;
        for (int r = 0; r < ROUNDS; r++) begin
            s = s + DELTA;
            a = a + (((b << 4) + key[31:0]) ^ (b + s) ^ ((b >> 5) + key[63:32]));
            b = b + (((a << 4) + key[95:64]) ^ (a + s) ^ ((a >> 5) + key[127:96]));
        end
        return {a, b};
    endfunction

    task automatic set_inputs(input logic [31:0] c0, input logic [31:0] c1, input logic [127:0] key);
        v0_in = c0; v1_in = c1;
        {k3, k2, k1, k0} = key;
    endtask

    task automatic add_block(input logic [31:0] p0, input logic [31:0] p1, input logic [127:0] key);
        logic [63:0] ct;
        ct = tea_enc(p0, p1, key);
        st_v0.push_back(ct[63:32]);
        st_v1.push_back(ct[31:0]);
        st_key.push_back(key);
        ex_pt.push_back({p0, p1});
    endtask

    // Streams the queued blocks with in_valid and out_ready held high; entered and left at a negedge.
    task automatic process_blocks(input string tag);
        int n, sent, got, cyc, budget, last_acc, a;
        bit acc, outv, have_last;
        logic [63:0] sb[$];
        int acc_q[$];
        logic [63:0] exp_w;
        n = st_v0.size(); sent = 0; got = 0; cyc = 0; have_last = 0; last_acc = 0;
        budget = n * (ROUNDS + 2) + 40;
        out_ready = 1'b1;
        while (got < n && cyc < budget) begin
            if (sent < n) begin
                in_valid = 1'b1;
                set_inputs(st_v0[sent], st_v1[sent], st_key[sent]);
            end else begin
                in_valid = 1'b0;
                set_inputs($urandom, $urandom, {$urandom, $urandom, $urandom, $urandom});
            end
            acc  = in_ready && in_valid;
            outv = out_valid && out_ready;
            if (outv) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s unexpected_out_valid: got out_valid=1 at cycle %0d, required 0 (nothing in flight)", tag, cyc);
                end else begin
                    exp_w = sb.pop_front();
                    a = acc_q.pop_front();
                    if ({v0_out, v1_out} !== exp_w) begin
                        n_fail++;
                        $display("FAIL %s plaintext: got %h_%h required %h_%h", tag, v0_out, v1_out, exp_w[63:32], exp_w[31:0]);
                    end
                    n_checks++;
                    if (cyc - 1 - a !== ROUNDS) begin
                        n_fail++;
                        $display("FAIL %s latency: got %0d edges required %0d", tag, cyc - 1 - a, ROUNDS);
                    end
                end
                got++;
            end
            @(posedge clk);
            if (acc) begin
                sb.push_back(ex_pt[sent]);
                acc_q.push_back(cyc);
                if (have_last) begin
                    n_checks++;
                    if (cyc - last_acc !== ROUNDS + 2) begin
                        n_fail++;
                        $display("FAIL %s accept_spacing: got %0d cycles required %0d", tag, cyc - last_acc, ROUNDS + 2);
                    end
                end
                last_acc = cyc; have_last = 1; sent++;
            end
            cyc++;
            @(negedge clk);
        end
        n_checks++;
        if (got !== n) begin
            n_fail++;
            $display("FAIL %s timeout: got %0d results required %0d", tag, got, n);
        end
        $display("%s: %0d blocks sent, %0d results received in %0d cycles", tag, sent, got, cyc);
        in_valid = 1'b0;
        st_v0.delete(); st_v1.delete(); st_key.delete(); ex_pt.delete();
    endtask

    task automatic test_reset();
        #2;
        n_checks += 5;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b required 0", out_valid); end
        if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset in_ready: got %b required 1", in_ready); end
        if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset busy: got %b required 0", busy); end
        if (v0_out !== 32'd0)   begin n_fail++; $display("FAIL reset v0_out: got %h required 0", v0_out); end
        if (v1_out !== 32'd0)   begin n_fail++; $display("FAIL reset v1_out: got %h required 0", v1_out); end
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        $display("reset: state checked, reset released");
    endtask

    task automatic test_known_vector();
        st_v0.push_back(32'h41EA3A0A);
        st_v1.push_back(32'h94BAA940);
        st_key.push_back(128'd0);
        ex_pt.push_back(64'd0);
        process_blocks("known_vector");
    endtask

    task automatic test_round_trip();
        for (int i = 0; i < 200; i++)
            add_block($urandom, $urandom, {$urandom, $urandom, $urandom, $urandom});
        process_blocks("round_trip");
    endtask

    task automatic test_back_to_back();
        add_block(32'h01234567, 32'h89ABCDEF, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        add_block(32'hFFFFFFFF, 32'h00000000, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF);
        add_block(32'hDEADBEEF, 32'hCAFEF00D, 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0);
        process_blocks("back_to_back");
    endtask

    task automatic test_input_change();
        logic [127:0] key;
        logic [63:0] ct;
        logic [31:0] p0, p1;
        bit rdy, seen;
        p0 = 32'h13579BDF; p1 = 32'h2468ACE0;
        key = 128'hA5A5A5A5_5A5A5A5A_3C3C3C3C_C3C3C3C3;
        ct = tea_enc(p0, p1, key);
        out_ready = 1'b1;
        in_valid = 1'b1;
        set_inputs(ct[63:32], ct[31:0], key);
        rdy = 0;
        for (int i = 0; i < 10 && !rdy; i++) begin
            rdy = in_ready;
            @(posedge clk);
        end
        seen = 0;
        for (int i = 0; i < ROUNDS + 5 && !seen; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            seen = out_valid;
            if (!seen) set_inputs($urandom, $urandom, {$urandom, $urandom, $urandom, $urandom});
        end
        n_checks += 2;
        if (!seen) begin n_fail++; $display("FAIL input_change timeout: out_valid never rose"); end
        if ({v0_out, v1_out} !== {p0, p1}) begin
            n_fail++;
            $display("FAIL input_change plaintext: got %h_%h required %h_%h", v0_out, v1_out, p0, p1);
        end
        @(posedge clk);
        @(negedge clk);
        $display("input_change: result %h_%h", v0_out, v1_out);
    endtask

    task automatic test_backpressure();
        logic [127:0] ka, kb;
        logic [63:0] cta, ctb;
        logic [31:0] pa0, pa1, pb0, pb1;
        bit rdy, seen;
        pa0 = 32'h11112222; pa1 = 32'h33334444; ka = 128'h01010101_02020202_03030303_04040404;
        pb0 = 32'h55556666; pb1 = 32'h77778888; kb = 128'h10203040_50607080_90A0B0C0_D0E0F000;
        cta = tea_enc(pa0, pa1, ka);
        ctb = tea_enc(pb0, pb1, kb);
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_inputs(cta[63:32], cta[31:0], ka);
        rdy = 0;
        for (int i = 0; i < 10 && !rdy; i++) begin
            rdy = in_ready;
            @(posedge clk);
        end
        seen = 0;
        for (int i = 0; i < ROUNDS + 5 && !seen; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            seen = out_valid;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL backpressure timeout: out_valid never rose"); end
        for (int i = 0; i < 10; i++) begin
            n_checks += 3;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL backpressure in_ready: got %b required 0 (hold %0d)", in_ready, i); end
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL backpressure out_valid: got %b required 1 (hold %0d)", out_valid, i); end
            if ({v0_out, v1_out} !== {pa0, pa1}) begin
                n_fail++;
                $display("FAIL backpressure hold_data: got %h_%h required %h_%h (hold %0d)", v0_out, v1_out, pa0, pa1, i);
            end
            in_valid = i[0];
            set_inputs($urandom, $urandom, {$urandom, $urandom, $urandom, $urandom});
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b1;
        set_inputs(ctb[63:32], ctb[31:0], kb);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks += 3;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL backpressure release_out_valid: got %b required 0", out_valid); end
        if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL backpressure release_in_ready: got %b required 1", in_ready); end
        if ({v0_out, v1_out} !== {pa0, pa1}) begin
            n_fail++;
            $display("FAIL backpressure kept_data: got %h_%h required %h_%h", v0_out, v1_out, pa0, pa1);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL backpressure accept_waiting: busy=%b required 1", busy); end
        seen = 0;
        for (int i = 0; i < ROUNDS + 5 && !seen; i++) begin
            seen = out_valid;
            if (!seen) begin @(posedge clk); @(negedge clk); end
        end
        n_checks += 2;
        if (!seen) begin n_fail++; $display("FAIL backpressure second_timeout: out_valid never rose"); end
        if ({v0_out, v1_out} !== {pb0, pb1}) begin
            n_fail++;
            $display("FAIL backpressure second_plaintext: got %h_%h required %h_%h", v0_out, v1_out, pb0, pb1);
        end
        @(posedge clk);
        @(negedge clk);
        $display("backpressure: held %h_%h, then decoded %h_%h", pa0, pa1, v0_out, v1_out);
    endtask

    task automatic test_async_reset();
        bit rdy;
        out_ready = 1'b1;
        in_valid = 1'b1;
        set_inputs(32'h41EA3A0A, 32'h94BAA940, 128'd0);
        rdy = 0;
        for (int i = 0; i < 10 && !rdy; i++) begin
            rdy = in_ready;
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #2 nrst = 1'b0;
        #1;
        n_checks += 5;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset out_valid: got %b required 0", out_valid); end
        if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL async_reset in_ready: got %b required 1", in_ready); end
        if (busy !== 1'b0)      begin n_fail++; $display("FAIL async_reset busy: got %b required 0", busy); end
        if (v0_out !== 32'd0)   begin n_fail++; $display("FAIL async_reset v0_out: got %h required 0", v0_out); end
        if (v1_out !== 32'd0)   begin n_fail++; $display("FAIL async_reset v1_out: got %h required 0", v1_out); end
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        $display("async_reset: aborted at round 15, reset released");
        test_known_vector();
    endtask

    initial begin
        test_reset();
        test_known_vector();
        test_round_trip();
        test_back_to_back();
        test_input_change();
        test_backpressure();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tea_decrypt_iter.md
Name: tea_decrypt_iter

Overview:
- Iterative TEA block decryptor: the inverse of the team's pipelined TEA encryptor.
- Takes a 64-bit ciphertext (v0, v1) and a 128-bit key through a valid/ready handshake.
- Runs one decryption round per clock and returns the 64-bit plaintext through a second valid/ready handshake.
- Sits on the receive side of the TEA link, trading throughput for area: one round datapath instead of 32 pipeline stages.

Parameters:
- ROUNDS, 32: number of TEA cycles. Must match the encryptor; legal range 1..63.
- DELTA, 32'h9E3779B9: TEA key-schedule constant.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  ciphertext/key presented.
- in_ready  out  1  block can accept a new ciphertext.
- v0_in  in  32  ciphertext word 0.
- v1_in  in  32  ciphertext word 1.
- k0, k1, k2, k3  in  32 each  key words.
- out_valid  out  1  plaintext available.
- out_ready  in  1  downstream accepts the plaintext.
- v0_out  out  32  plaintext word 0.
- v1_out  out  32  plaintext word 1.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (nrst low, asynchronous, takes effect immediately without a clock edge):
  - state=IDLE, round counter=0.
  - Internal v0/v1/sum/key registers = 0.
  - v0_out=0, v1_out=0, out_valid=0, busy=0, in_ready=1.
  - Deassertion is sampled synchronously; the first accept can occur at the first rising edge with nrst high.
- States:
  - IDLE: in_ready=1. On an edge with in_valid=1:
    - latch v0_in, v1_in and {k3,k2,k1,k0}.
    - load sum = (DELTA*ROUNDS) mod 2^32; this is 32'hC6EF3720 for ROUNDS=32.
    - counter=0; go to RUN.
  - RUN: in_ready=0. Each edge performs one round, with all arithmetic mod 2^32 and logical (zero-fill) shifts:
    - v1' = v1 - (((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3))
    - v0' = v0 - (((v1'<<4)+k0) ^ (v1'+sum) ^ ((v1'>>5)+k1)), computed using the updated v1'.
    - sum' = sum - DELTA; counter+1.
    - On the edge where counter==ROUNDS-1: register v0', v1' into v0_out/v1_out, set out_valid=1, go to DONE.
  - DONE: out_valid=1 and outputs stable.
    - On an edge with out_ready=1: out_valid=0 and go to IDLE.
    - v0_out/v1_out keep their last values after the handshake.
- Latency and throughput:
  - out_valid rises exactly ROUNDS edges after the accept edge.
  - Throughput: one block per ROUNDS+2 cycles when out_ready is held high.
- Input stability: v0_in, v1_in and k* changes after the accept edge have no effect on the block in flight.
- in_valid while not in IDLE: ignored; the upstream holds its data until in_ready is seen.
- out_ready in IDLE or RUN: ignored.
- Backpressure: out_ready low in DONE holds the result indefinitely, with no state loss.
- Reset mid-RUN or mid-DONE: the block is aborted; no out_valid pulse appears afterwards.
- Counter width: 6 bits. The sum wraps naturally mod 2^32.

Test Plan:
- Known vector:
  - Stimulus: key all-zero, ciphertext v0=32'h41EA3A0A, v1=32'h94BAA940.
  - Required: plaintext 0/0, with out_valid rising exactly 32 edges after the accept edge.
- Round-trip:
  - Stimulus: 200 random keys/plaintexts encrypted by a reference TEA model, then fed to the block.
  - Required: every output equals the original plaintext.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles in DONE, and during that time toggle in_valid with new data.
  - Required: in_ready=0, outputs stable, the new data is not accepted. On out_ready=1 the block returns to IDLE and accepts the waiting data on the next edge.
- Input change after accept:
  - Stimulus: change k0..k3 and v0_in/v1_in every cycle during RUN.
  - Required: the result matches the values latched at the accept edge.
- Async reset mid-RUN:
  - Stimulus: drop nrst between edges at round 15.
  - Required: out_valid=0, in_ready=1, outputs 0 immediately (before the next edge). After release, a fresh known vector decrypts correctly with no stale out_valid.
- Back-to-back:
  - Stimulus: three blocks with in_valid and out_ready held high.
  - Required: accepts spaced exactly ROUNDS+2=34 cycles apart, all three results correct and in order.
